// File: rtl/smc_counter_lite18_pkg.sv
// Shared widths and constants for the SMC18 timing-counter stage.
// Covers default field widths, zero constants and counter slot indices.
package smc_counter_lite18_pkg;

  localparam int TIM_W_DEF = 2;
  localparam int WS_W_DEF  = 8;

  localparam logic [TIM_W_DEF-1:0] TIM_ZERO = '0;
  localparam logic [WS_W_DEF-1:0]  WS_ZERO  = '0;

  // Slots of the two narrow counters built by the generate loop in the top.
  localparam int CTR_CSLE = 0;
  localparam int CTR_CSTE = 1;
  localparam int N_TIM_CTR = 2;

endpackage

// File: rtl/smc_counter_lite18_if.sv
// Control/config/count bundle between the SMC18 state machine (master)
// and the timing-counter stage (slave).
interface smc_counter_lite18_if
  import smc_counter_lite18_pkg::*;
#(
  parameter int TIM_W = TIM_W_DEF,
  parameter int WS_W  = WS_W_DEF
);

  logic             valid_access18;
  logic             le_enable18;
  logic             ws_enable18;
  logic             cste_enable18;
  logic             smc_done18;
  logic [TIM_W-1:0] csle_tim18;
  logic [TIM_W-1:0] cste_tim18;
  logic [TIM_W-1:0] oete_tim18;
  logic [WS_W-1:0]  ws_tim18;

  logic [TIM_W-1:0] r_csle_count18;
  logic [TIM_W-1:0] r_cste_count18;
  logic [WS_W-1:0]  r_ws_count18;
  logic [TIM_W-1:0] r_csle_store18;
  logic [TIM_W-1:0] r_oete_store18;
  logic [TIM_W-1:0] r_cste_store18;
  logic [WS_W-1:0]  r_ws_store18;

  modport master (
    output valid_access18, le_enable18, ws_enable18, cste_enable18, smc_done18,
    output csle_tim18, cste_tim18, oete_tim18, ws_tim18,
    input  r_csle_count18, r_cste_count18, r_ws_count18,
    input  r_csle_store18, r_oete_store18, r_cste_store18, r_ws_store18
  );

  modport slave (
    input  valid_access18, le_enable18, ws_enable18, cste_enable18, smc_done18,
    input  csle_tim18, cste_tim18, oete_tim18, ws_tim18,
    output r_csle_count18, r_cste_count18, r_ws_count18,
    output r_csle_store18, r_oete_store18, r_cste_store18, r_ws_store18
  );

endinterface

// File: rtl/smc_counter_lite18_dn_counter.sv
// Saturating down-counter: load beats reload, reload beats decrement,
// and a decrement request at zero holds zero.
module smc_dn_counter18 #(
  parameter int W = 2
) (
  input  logic         sys_clk18,
  input  logic         n_sys_reset18,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         reload,
  input  logic [W-1:0] reload_val,
  input  logic         enable,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (reload) begin
      count_next = reload_val;
    end else if (enable && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge sys_clk18 or negedge n_sys_reset18) begin
    if (!n_sys_reset18) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/smc_counter_lite18.sv
// SMC18 timing-counter stage: per-access config stores plus the CSLE,
// CSTE and wait-state down-counters decoded by the state machine.
module smc_counter_lite18
  import smc_counter_lite18_pkg::*;
#(
  parameter int TIM_W = TIM_W_DEF,
  parameter int WS_W  = WS_W_DEF
) (
  input logic                 sys_clk18,
  input logic                 n_sys_reset18,
  smc_counter_lite18_if.slave bus
);

  logic [TIM_W-1:0] csle_store_reg;
  logic [TIM_W-1:0] oete_store_reg;
  logic [TIM_W-1:0] cste_store_reg;
  logic [WS_W-1:0]  ws_store_reg;

  // Stores are written only by a new access; beats of a multiple access
  // reload their counters from here.
  always_ff @(posedge sys_clk18 or negedge n_sys_reset18) begin
    if (!n_sys_reset18) begin
      csle_store_reg <= '0;
      oete_store_reg <= '0;
      cste_store_reg <= '0;
      ws_store_reg   <= '0;
    end else if (bus.valid_access18) begin
      csle_store_reg <= bus.csle_tim18;
      oete_store_reg <= bus.oete_tim18;
      cste_store_reg <= bus.cste_tim18;
      ws_store_reg   <= bus.ws_tim18;
    end
  end

  logic [TIM_W-1:0] tim_cfg   [N_TIM_CTR];
  logic [TIM_W-1:0] tim_store [N_TIM_CTR];
  logic             tim_en    [N_TIM_CTR];
  logic [TIM_W-1:0] tim_count [N_TIM_CTR];

  assign tim_cfg[CTR_CSLE]   = bus.csle_tim18;
  assign tim_cfg[CTR_CSTE]   = bus.cste_tim18;
  assign tim_store[CTR_CSLE] = csle_store_reg;
  assign tim_store[CTR_CSTE] = cste_store_reg;
  assign tim_en[CTR_CSLE]    = bus.le_enable18;
  assign tim_en[CTR_CSTE]    = bus.cste_enable18;

  generate
    for (genvar gi = 0; gi < N_TIM_CTR; gi++) begin : g_tim_ctr
      smc_dn_counter18 #(.W(TIM_W)) u_ctr (
        .sys_clk18     (sys_clk18),
        .n_sys_reset18 (n_sys_reset18),
        .load          (bus.valid_access18),
        .load_val      (tim_cfg[gi]),
        .reload        (bus.smc_done18),
        .reload_val    (tim_store[gi]),
        .enable        (tim_en[gi]),
        .count         (tim_count[gi])
      );
    end
  endgenerate

  logic [WS_W-1:0] ws_count;

  smc_dn_counter18 #(.W(WS_W)) u_ws_ctr (
    .sys_clk18     (sys_clk18),
    .n_sys_reset18 (n_sys_reset18),
    .load          (bus.valid_access18),
    .load_val      (bus.ws_tim18),
    .reload        (bus.smc_done18),
    .reload_val    (ws_store_reg),
    .enable        (bus.ws_enable18),
    .count         (ws_count)
  );

  assign bus.r_csle_count18 = tim_count[CTR_CSLE];
  assign bus.r_cste_count18 = tim_count[CTR_CSTE];
  assign bus.r_ws_count18   = ws_count;
  assign bus.r_csle_store18 = csle_store_reg;
  assign bus.r_oete_store18 = oete_store_reg;
  assign bus.r_cste_store18 = cste_store_reg;
  assign bus.r_ws_store18   = ws_store_reg;

endmodule

// File: doc/smc_counter_lite18.md
Name: smc_counter_lite18

Overview:
- Timing-counter stage that feeds the SMC18 state machine.
- Captures per-access timing configuration (CSLE, CSTE, OETE, wait states) when a new access is accepted.
- Runs the chip-select leading-edge, wait-state and chip-select trailing-edge down-counters under the state machine's enables.
- Returns the registered counts and stored values that the state machine decodes for its transitions, done, latch_data and valid_access logic.

Parameters:
- WS_W, 8, width of the wait-state counter and config field.
- TIM_W, 2, width of the CSLE/CSTE/OETE counters and config fields.

Ports:
- sys_clk18  in  1  AHB18 system clock
- n_sys_reset18  in  1  system reset, asynchronous, active low
- valid_access18  in  1  new access accepted; load config this cycle
- le_enable18  in  1  decrement CSLE counter
- ws_enable18  in  1  decrement wait-state counter
- cste_enable18  in  1  decrement CSTE counter
- smc_done18  in  1  last cycle of current beat; reload counters from stores
- csle_tim18  in  TIM_W  configured CS leading-edge delay
- cste_tim18  in  TIM_W  configured CS trailing-edge delay
- oete_tim18  in  TIM_W  configured read-strobe TE before CS
- ws_tim18  in  WS_W  configured wait states
- r_csle_count18  out  TIM_W  CSLE down-counter
- r_cste_count18  out  TIM_W  CSTE down-counter
- r_ws_count18  out  WS_W  wait-state down-counter
- r_csle_store18  out  TIM_W  stored CSLE for repeat beats
- r_oete_store18  out  TIM_W  stored OETE
- r_cste_store18  out  TIM_W  stored CSTE
- r_ws_store18  out  WS_W  stored wait states

Behaviour:
- Interface: one clock, sys_clk18; reset n_sys_reset18 is asynchronous and active-low.
- Reset: all outputs 0, asserted asynchronously and held until the first sys_clk18 rising edge after release.
- Reset mid-access forces all counts and stores to 0 immediately; no residual count survives.
- All outputs are registered; every input acts on the next rising edge, so latency is 1 cycle.

Stores:
- Loaded when valid_access18=1: csle_tim18 to r_csle_store18, and likewise for oete, cste and ws.
- Otherwise hold. Only valid_access18 writes them.

Counter update, per counter X in {csle, cste, ws}, in strict priority order:
1. valid_access18=1: count <= X_tim18 (the new config, not the old store).
2. else smc_done18=1: count <= r_X_store18 (reload for the next beat of a multiple access).
3. else X_enable18=1 and count!=0: count <= count-1.
4. else: hold.

Counter boundaries:
- Counters never wrap. A decrement request at 0 holds 0.
- The CSLE counter decrements only on le_enable18; r_csle_count18 is not cleared when the state machine leaves LE.
- ws_enable18 together with a value of 1 gives 0 on the next cycle; the RW exit condition ws==0 is then visible one cycle later.
- The CSTE counter holds its loaded value through RW and decrements only while cste_enable18=1 (next state FLOAT).

Simultaneous events:
- valid_access18 with smc_done18: config load wins (back-to-back access, RW->STORE or FLOAT->RW with a new access).
- Any enable with smc_done18: reload wins.
- All three enables may be active at once; each counter is independent.

Config timing:
- Config inputs are sampled only when valid_access18=1 and may change freely at other times.
- The block is purely counters and stores; it has no state machine of its own.

Decomposition:
- Shared include smc_defs_lite18: TIM_W and WS_W defaults and a zero-constant per width.
- Natural sub-module: smc_dn_counter18, parameterised width W, with load, reload and enable priority, saturating at 0. It is instantiated three times.
- The stores stay in the top level.

Test Plan:
- Reset: assert n_sys_reset18 mid-count with ws=0x2A -> all outputs 0 asynchronously; still 0 after release until the next valid_access18.
- Load/decrement: ws_tim18=3 with valid_access18, then ws_enable18 held -> r_ws_count18 sequence 3,2,1,0,0; r_ws_store18=3 throughout.
- CSLE: csle_tim18=2 with valid_access18, then le_enable18 for 3 cycles -> r_csle_count18 2,1,0,0; r_csle_store18=2.
- CSTE: cste_tim18=2, ws=0 load, cste_enable18 two cycles -> 2,1,0; pulse smc_done18 -> r_cste_count18 reloads 2.
- Priority: valid_access18 and smc_done18 together with stores=1 and config=3 -> all counts 3 and stores 3 next cycle; smc_done18 with ws_enable18 -> reload, no decrement.
- Saturation: r_ws_count18=0 and ws_enable18 for 5 cycles -> stays 0; config WS=0xFF load -> 0xFF, no overflow on decrement.
